fb_scan_sched: RTL and testbench

FB_SCAN_SCHED -- requirements
Module: fb_scan_sched

---
 rtl/fb_scan_sched.sv | 159 +++++++++++++++
 tb/tb_fb_scan_sched.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fb_scan_sched.sv
// Raster scan scheduler: walks a cell-tiled framebuffer and emits cell index, sub-pixel offsets, syncs and vblank IRQ.
// Latency: 1 clock from counters to outputs. Backpressure: none; the scan free-runs once enabled.
module fb_scan_sched #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int HS_START = 656,
    parameter int HS_END   = 752,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int VS_START = 490,
    parameter int VS_END   = 492,
    parameter int CELL_LG2 = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [7:0]          cell_stride_i,
    input  logic                irq_ack_i,
    output logic [13:0]         pix_cell_ix_o,
    output logic [CELL_LG2-1:0] pix_sub_x_o,
    output logic [CELL_LG2-1:0] pix_sub_y_o,
    output logic                pix_active_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                frame_irq_o,
    output logic                irq_ovf_o,
    output logic [7:0]          frame_count_o
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_S   = HW'(HS_START);
    localparam logic [HW-1:0] HS_E   = HW'(HS_END);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_S   = VW'(VS_START);
    localparam logic [VW-1:0] VS_E   = VW'(VS_END);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [HW-1:0]       h_cnt_q, h_cnt_d;
    logic [VW-1:0]       v_cnt_q, v_cnt_d, v_nxt;
    logic [13:0]         row_base_q, row_base_d;
    logic [7:0]          stride_q, stride_d;
    logic [13:0]         cell_ix_q, cell_ix_d;
    logic [CELL_LG2-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic                active_q, active_d, hs_q, hs_d, vs_q, vs_d;
    logic                irq_q, irq_d, ovf_q, ovf_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                running, h_last, eof, vis, vblank;

    always_comb begin
        running    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        h_last     = (h_cnt_q == H_LAST);
        eof        = h_last && (v_cnt_q == V_LAST);
        v_nxt      = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        state_d    = state_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        row_base_d = row_base_q;
        stride_d   = stride_q;

        case (state_q)
            ST_IDLE:  if (enable_i) begin
                          state_d  = ST_RUN;
                          stride_d = cell_stride_i;
                      end
            ST_RUN:   if (!enable_i) state_d = ST_DRAIN;
            ST_DRAIN: if (enable_i) state_d = ST_RUN;
                      else if (eof) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Row base advances by stride at each cell-row boundary, avoiding a multiplier.
        if (running) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
            if (h_last) begin
                v_cnt_d = v_nxt;
                if (v_nxt == '0) begin
                    row_base_d = '0;
                    stride_d   = cell_stride_i;
                end else if ((v_nxt[CELL_LG2-1:0] == '0) && (v_nxt < V_ACT)) begin
                    row_base_d = row_base_q + {6'b0, stride_q};
                end
            end
        end
    end

    always_comb begin
        vis       = running && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        cell_ix_d = vis ? row_base_q + 14'(h_cnt_q >> CELL_LG2) : '0;
        sub_x_d   = vis ? h_cnt_q[CELL_LG2-1:0] : '0;
        sub_y_d   = vis ? v_cnt_q[CELL_LG2-1:0] : '0;
        active_d  = vis;
        hs_d      = running && (h_cnt_q >= HS_S) && (h_cnt_q < HS_E);
        vs_d      = running && (v_cnt_q >= VS_S) && (v_cnt_q < VS_E);
        vblank    = running && (h_cnt_q == '0) && (v_cnt_q == V_ACT);
        irq_d     = irq_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        // An ack landing on the vblank clock retires the old request but the new one still posts.
        if (vblank) begin
            irq_d = 1'b1;
            ovf_d = irq_ack_i ? 1'b0 : (ovf_q | irq_q);
            cnt_d = cnt_q + 8'd1;
        end else if (irq_ack_i) begin
            irq_d = 1'b0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            row_base_q <= '0;
            stride_q   <= '0;
            cell_ix_q  <= '0;
            sub_x_q    <= '0;
            sub_y_q    <= '0;
            active_q   <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            row_base_q <= row_base_d;
            stride_q   <= stride_d;
            cell_ix_q  <= cell_ix_d;
            sub_x_q    <= sub_x_d;
            sub_y_q    <= sub_y_d;
            active_q   <= active_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pix_cell_ix_o = cell_ix_q;
    assign pix_sub_x_o   = sub_x_q;
    assign pix_sub_y_o   = sub_y_q;
    assign pix_active_o  = active_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign frame_irq_o   = irq_q;
    assign irq_ovf_o     = ovf_q;
    assign frame_count_o = cnt_q;
endmodule

// File: tb/tb_fb_scan_sched.sv
// Directed bench for fb_scan_sched: small 20x20 raster plus a tall raster for row-base wrap.
module tb_fb_scan_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        enable_b = 1'b0;
    logic [7:0]  stride = 8'd2;
    logic        ack = 1'b0;

    logic [13:0] ix, ix_b;
    logic [2:0]  sx, sy, sx_b, sy_b;
    logic        act, hs, vs, irq, ovf;
    logic        act_b, hs_b, vs_b, irq_b, ovf_b;
    logic [7:0]  cnt, cnt_b;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fb_scan_sched #(.H_ACTIVE(16), .H_TOTAL(20), .HS_START(17), .HS_END(19),
                    .V_ACTIVE(16), .V_TOTAL(20), .VS_START(17), .VS_END(19),
                    .CELL_LG2(3)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .cell_stride_i(stride),
        .irq_ack_i(ack), .pix_cell_ix_o(ix), .pix_sub_x_o(sx), .pix_sub_y_o(sy),
        .pix_active_o(act), .hsync_o(hs), .vsync_o(vs), .frame_irq_o(irq),
        .irq_ovf_o(ovf), .frame_count_o(cnt));

    fb_scan_sched #(.H_ACTIVE(16), .H_TOTAL(20), .HS_START(17), .HS_END(19),
                    .V_ACTIVE(576), .V_TOTAL(580), .VS_START(577), .VS_END(579),
                    .CELL_LG2(3)) u_big (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable_b), .cell_stride_i(stride),
        .irq_ack_i(1'b0), .pix_cell_ix_o(ix_b), .pix_sub_x_o(sx_b), .pix_sub_y_o(sy_b),
        .pix_active_o(act_b), .hsync_o(hs_b), .vsync_o(vs_b), .frame_irq_o(irq_b),
        .irq_ovf_o(ovf_b), .frame_count_o(cnt_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected small-raster outputs for scan position p; idle forces everything low.
    task automatic chk_pos(input int p, input int s, input bit idle);
        int h, v, e_ix, e_sx, e_sy;
        bit vis, e_hs, e_vs;
        h    = p % 20;
        v    = p / 20;
        vis  = !idle && h < 16 && v < 16;
        e_ix = vis ? (((v / 8) * s + h / 8) % 16384) : 0;
        e_sx = vis ? h % 8 : 0;
        e_sy = vis ? v % 8 : 0;
        e_hs = !idle && h >= 17 && h < 19;
        e_vs = !idle && v >= 17 && v < 19;
        chk($sformatf("ix@%0d", p), 32'(ix), 32'(e_ix));
        chk($sformatf("subx@%0d", p), 32'(sx), 32'(e_sx));
        chk($sformatf("suby@%0d", p), 32'(sy), 32'(e_sy));
        chk($sformatf("act@%0d", p), 32'(act), 32'(vis));
        chk($sformatf("hs@%0d", p), 32'(hs), 32'(e_hs));
        chk($sformatf("vs@%0d", p), 32'(vs), 32'(e_vs));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ix", 32'(ix), 0);
        chk("rst_act", 32'(act), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_cnt", 32'(cnt), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_act", 32'(act), 0);
        chk("idle_hs", 32'(hs), 0);

        // Three frames: stride change mid-frame 2, ack at frame 3 start, drain in frame 3.
        enable = 1'b1;
        tick();
        for (int k = 0; k < 1210; k++) begin
            tick();
            chk_pos(k % 400, (k < 800) ? 2 : 5, k >= 1200);
            chk($sformatf("irq@%0d", k), 32'(irq),
                32'((k >= 320 && k < 800) || k >= 1120));
            chk($sformatf("ovf@%0d", k), 32'(ovf), 32'(k >= 720 && k < 800));
            chk($sformatf("cnt@%0d", k), 32'(cnt),
                32'(k >= 320) + 32'(k >= 720) + 32'(k >= 1120));
            if (k == 500) stride = 8'd5;
            if (k == 799) ack = 1'b1;
            if (k == 800) ack = 1'b0;
            if (k == 899) enable = 1'b0;
            if (k == 949) enable = 1'b1;
            if (k == 999) enable = 1'b0;
        end

        // Restart with a pending IRQ; ack lands on the vblank clock.
        stride = 8'd255;
        enable = 1'b1;
        tick();
        for (int j = 0; j < 467; j++) begin
            tick();
            chk_pos(j % 400, 255, 1'b0);
            chk($sformatf("irq2@%0d", j), 32'(irq), 1);
            chk($sformatf("ovf2@%0d", j), 32'(ovf), 0);
            chk($sformatf("cnt2@%0d", j), 32'(cnt), (j >= 320) ? 4 : 3);
            if (j == 319) ack = 1'b1;
            if (j == 320) ack = 1'b0;
        end

        // Counters now at h=7, v=3: reset must clear outputs without a clock edge.
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("arst_ix", 32'(ix), 0);
        chk("arst_subx", 32'(sx), 0);
        chk("arst_suby", 32'(sy), 0);
        chk("arst_act", 32'(act), 0);
        chk("arst_irq", 32'(irq), 0);
        chk("arst_cnt", 32'(cnt), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk_pos(0, 0, 1'b1);
            chk($sformatf("post_cnt@%0d", i), 32'(cnt), 0);
        end

        // Tall raster: 72 cell rows at stride 255 forces row-base wrap past 2^14.
        enable_b = 1'b1;
        tick();
        for (int m = 0; m < 11600; m++) begin
            int h, v, e;
            bit vis;
            tick();
            h   = m % 20;
            v   = m / 20;
            vis = h < 16 && v < 576;
            e   = vis ? (((v / 8) * 255 + h / 8) % 16384) : 0;
            chk($sformatf("big_ix@%0d", m), 32'(ix_b), 32'(e));
            chk($sformatf("big_act@%0d", m), 32'(act_b), 32'(vis));
        end
        chk("big_cnt", 32'(cnt_b), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
